// File: rtl/snpu_pkg.sv
// Shared definitions for the SNPU policy-deck engine: opcodes, FSM states
// and the LFSR constants.
package snpu_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_RESET_DECK = 3'd1,
    OP_SHUFFLE    = 3'd2,
    OP_DRAW       = 3'd3,
    OP_PEEK       = 3'd4,
    OP_DISCARD    = 3'd5,
    OP_ENACT      = 3'd6,
    OP_STATUS     = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHUF = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Galois taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

endpackage

// File: rtl/snpu_lfsr.sv
// 16-bit Galois LFSR that free-runs every cycle; a seed load wins over the
// advance, and an all-zero seed is replaced by the init value to avoid lock-up.
module snpu_lfsr
  import snpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_INIT;
    end else if (seed_valid) begin
      lfsr <= (seed == 16'h0000) ? LFSR_INIT : seed;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/snpu_policy_deck.sv
// Policy-deck engine: one bit per card, regions stack|hand|discard|board from
// position 0 upward, single-cycle deck commands plus a multi-cycle shuffle.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | accepting commands, non-shuffle ops finish here
//   ST_SHUF | Fisher-Yates walk over the merged stack, i down to 1
//   ST_DONE | merge counters and pulse the shuffle response
module snpu_policy_deck
  import snpu_pkg::*;
#(
  parameter int N_CARDS  = 17,
  parameter int N_ONES   = 6,
  parameter int HAND_MAX = 3,
  parameter int CW       = $clog2(N_CARDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd_op,
  input  logic [2:0]    cmd_idx,
  output logic          cmd_ready,
  input  logic          seed_valid,
  input  logic [15:0]   seed,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [7:0]    rsp_data,
  output logic          busy,
  output logic [CW-1:0] n_stack,
  output logic [CW-1:0] n_hand,
  output logic [CW-1:0] n_discard,
  output logic [CW-1:0] board_zeros,
  output logic [CW-1:0] board_ones
);

  localparam logic [N_CARDS:0]   ONE_W     = {{N_CARDS{1'b0}}, 1'b1};
  localparam logic [N_CARDS-1:0] INIT_DECK = N_CARDS'((ONE_W << N_ONES) - ONE_W);
  localparam logic [CW-1:0]      N_W       = CW'(N_CARDS);
  localparam logic [CW-1:0]      HAND_W    = CW'(HAND_MAX);
  localparam logic [CW-1:0]      ONE_CW    = CW'(1);
  localparam logic [CW-1:0]      TWO_CW    = CW'(2);

  // Position-based helpers built from masks so no variable bit-select is needed
  function automatic logic [N_CARDS-1:0] below(input int n);
    return N_CARDS'((ONE_W << n) - ONE_W);
  endfunction

  function automatic logic [N_CARDS-1:0] onehot(input int n);
    return below(n + 1) & ~below(n);
  endfunction

  function automatic logic bit_at(input logic [N_CARDS-1:0] v, input int n);
    return |(v & onehot(n));
  endfunction

  // Moves the card at lo to hi-1, shifting (lo, hi) down by one
  function automatic logic [N_CARDS-1:0] rot_left(input logic [N_CARDS-1:0] v,
                                                  input int lo, input int hi);
    logic [N_CARDS-1:0] m_all;
    logic [N_CARDS-1:0] m_low;
    m_all = below(hi) & ~below(lo);
    m_low = below(hi - 1) & ~below(lo);
    return (v & ~m_all) | ((v >> 1) & m_low) | (bit_at(v, lo) ? onehot(hi - 1) : '0);
  endfunction

  function automatic logic [N_CARDS-1:0] swap(input logic [N_CARDS-1:0] v,
                                              input int a, input int b);
    logic [N_CARDS-1:0] oa;
    logic [N_CARDS-1:0] ob;
    oa = onehot(a);
    ob = onehot(b);
    return (v & ~(oa | ob)) | (bit_at(v, a) ? ob : '0) | (bit_at(v, b) ? oa : '0);
  endfunction

  // Smallest all-ones value covering i
  function automatic logic [CW-1:0] smear(input logic [CW-1:0] i);
    logic [CW-1:0] m;
    m = i;
    for (int b = 1; b < CW; b = b * 2) m = m | (m >> b);
    return m;
  endfunction

  state_e             state;
  logic [N_CARDS-1:0] cards;
  logic [N_CARDS-1:0] cards_nxt;
  logic [15:0]        lfsr_q;
  logic [CW-1:0]      shuf_i;
  logic [CW-1:0]      shuf_s;
  logic [CW-1:0]      j_draw;
  logic [CW-1:0]      idx_w;
  logic [CW-1:0]      s_nxt, h_nxt, d_nxt, bz_nxt, bo_nxt;
  logic [7:0]         data;
  logic               accept, err, go_shuf, j_ok, card;
  int                 s_pos, h_pos, d_pos, i_pos;
  logic               unused_lfsr;

  snpu_lfsr u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .lfsr       (lfsr_q)
  );

  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign idx_w       = CW'(cmd_idx);
  assign shuf_s      = n_stack + n_discard;
  assign j_draw      = lfsr_q[CW-1:0] & smear(shuf_i);
  assign j_ok        = (j_draw <= shuf_i);
  assign unused_lfsr = ^lfsr_q[15:CW];

  always_comb begin
    err       = 1'b0;
    data      = 8'h00;
    go_shuf   = 1'b0;
    card      = 1'b0;
    cards_nxt = cards;
    s_nxt     = n_stack;
    h_nxt     = n_hand;
    d_nxt     = n_discard;
    bz_nxt    = board_zeros;
    bo_nxt    = board_ones;
    s_pos     = int'(n_stack);
    h_pos     = int'(n_hand);
    d_pos     = int'(n_discard);
    i_pos     = int'(idx_w);
    if (state == ST_SHUF) begin
      if (j_ok) cards_nxt = swap(cards, int'(shuf_i), int'(j_draw));
    end else begin
      case (op_e'(cmd_op))
        OP_NOP: ;
        OP_RESET_DECK: begin
          cards_nxt = INIT_DECK;
          s_nxt     = N_W;
          h_nxt     = '0;
          d_nxt     = '0;
          bz_nxt    = '0;
          bo_nxt    = '0;
        end
        OP_SHUFFLE: begin
          if (n_hand != '0) err = 1'b1;
          else go_shuf = 1'b1;
        end
        OP_DRAW: begin
          if (n_hand != '0 || n_stack < HAND_W) begin
            err = 1'b1;
          end else begin
            s_nxt = n_stack - HAND_W;
            h_nxt = HAND_W;
          end
        end
        OP_PEEK: begin
          if (idx_w >= n_hand) err = 1'b1;
          else data = {7'b0, bit_at(cards, s_pos + i_pos)};
        end
        OP_DISCARD: begin
          if (idx_w >= n_hand || n_hand < TWO_CW) begin
            err = 1'b1;
          end else begin
            cards_nxt = rot_left(cards, s_pos + i_pos, s_pos + h_pos);
            h_nxt     = n_hand - ONE_CW;
            d_nxt     = n_discard + ONE_CW;
          end
        end
        OP_ENACT: begin
          if (n_hand != ONE_CW) begin
            err = 1'b1;
          end else begin
            card      = bit_at(cards, s_pos);
            cards_nxt = rot_left(cards, s_pos, s_pos + 1 + d_pos);
            h_nxt     = '0;
            if (card) bo_nxt = board_ones + ONE_CW;
            else bz_nxt = board_zeros + ONE_CW;
          end
        end
        OP_STATUS: data = {4'(board_ones), 4'(board_zeros)};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cards       <= INIT_DECK;
      shuf_i      <= '0;
      n_stack     <= N_W;
      n_hand      <= '0;
      n_discard   <= '0;
      board_zeros <= '0;
      board_ones  <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 8'h00;
      case (state)
        ST_IDLE: begin
          if (accept && go_shuf) begin
            // Counters merge at DONE; the walk covers stack plus discard now
            if (shuf_s <= ONE_CW) begin
              state <= ST_DONE;
            end else begin
              state  <= ST_SHUF;
              shuf_i <= shuf_s - ONE_CW;
            end
          end else if (accept) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= err;
            rsp_data    <= data;
            cards       <= cards_nxt;
            n_stack     <= s_nxt;
            n_hand      <= h_nxt;
            n_discard   <= d_nxt;
            board_zeros <= bz_nxt;
            board_ones  <= bo_nxt;
          end
        end
        ST_SHUF: begin
          cards <= cards_nxt;
          if (j_ok) begin
            shuf_i <= shuf_i - ONE_CW;
            if (shuf_i == ONE_CW) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b1;
          n_stack   <= shuf_s;
          n_discard <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snpu_policy_deck.sv
// Directed bench for snpu_policy_deck with a small deck model and a reference
// Fisher-Yates walk driven by a software copy of the LFSR.
module tb_snpu_policy_deck;
  import snpu_pkg::*;

  localparam int N    = 17;
  localparam int CW   = 5;
  localparam int HAND = 3;
  localparam logic [N-1:0] INIT = 17'h0003F;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [2:0]    cmd_idx;
  logic          cmd_ready;
  logic          seed_valid;
  logic [15:0]   seed;
  logic          rsp_valid;
  logic          rsp_err;
  logic [7:0]    rsp_data;
  logic          busy;
  logic [CW-1:0] n_stack, n_hand, n_discard, board_zeros, board_ones;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] m_cards;
  int m_s, m_h, m_d, m_bz, m_bo;

  snpu_policy_deck dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_idx     (cmd_idx),
    .cmd_ready   (cmd_ready),
    .seed_valid  (seed_valid),
    .seed        (seed),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .n_stack     (n_stack),
    .n_hand      (n_hand),
    .n_discard   (n_discard),
    .board_zeros (board_zeros),
    .board_ones  (board_ones)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int fy_mask(input int i);
    int m;
    m = 1;
    while (m <= i) m = m * 2;
    return m - 1;
  endfunction

  function automatic logic [N-1:0] m_rot(input logic [N-1:0] v, input int lo, input int hi);
    logic [N-1:0] r;
    r = v;
    for (int k = lo; k < hi - 1; k++) r[k] = v[k + 1];
    r[hi - 1] = v[lo];
    return r;
  endfunction

  task automatic check_regions(input string tag);
    chk({tag, "_stack"},   32'(n_stack),     32'(m_s));
    chk({tag, "_hand"},    32'(n_hand),      32'(m_h));
    chk({tag, "_discard"}, 32'(n_discard),   32'(m_d));
    chk({tag, "_bz"},      32'(board_zeros), 32'(m_bz));
    chk({tag, "_bo"},      32'(board_ones),  32'(m_bo));
    chk({tag, "_deck"},    32'(dut.cards),   32'(m_cards));
  endtask

  task automatic model_reset();
    m_cards = INIT;
    m_s = N; m_h = 0; m_d = 0; m_bz = 0; m_bo = 0;
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] op, input int idx);
    logic e;
    logic [7:0] d;
    logic [N-1:0] nc;
    int ns, nh, nd, nbz, nbo;
    e = 1'b0; d = 8'h00; nc = m_cards;
    ns = m_s; nh = m_h; nd = m_d; nbz = m_bz; nbo = m_bo;
    case (op)
      OP_RESET_DECK: begin nc = INIT; ns = N; nh = 0; nd = 0; nbz = 0; nbo = 0; end
      OP_SHUFFLE: e = (m_h != 0);
      OP_DRAW: begin
        if (m_h != 0 || m_s < HAND) e = 1'b1;
        else begin ns = m_s - HAND; nh = HAND; end
      end
      OP_PEEK: begin
        if (idx >= m_h) e = 1'b1;
        else d = {7'b0, m_cards[m_s + idx]};
      end
      OP_DISCARD: begin
        if (idx >= m_h || m_h < 2) e = 1'b1;
        else begin nc = m_rot(m_cards, m_s + idx, m_s + m_h); nh = m_h - 1; nd = m_d + 1; end
      end
      OP_ENACT: begin
        if (m_h != 1) e = 1'b1;
        else begin
          nc = m_rot(m_cards, m_s, m_s + 1 + m_d);
          nh = 0;
          if (m_cards[m_s]) nbo = m_bo + 1;
          else nbz = m_bz + 1;
        end
      end
      OP_STATUS: d = {4'(m_bo), 4'(m_bz)};
      default: ;
    endcase
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = 3'(idx);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_err"},   32'(rsp_err),   32'(e));
    chk({tag, "_data"},  32'(rsp_data),  32'(d));
    if (!e) begin
      m_cards = nc; m_s = ns; m_h = nh; m_d = nd; m_bz = nbz; m_bo = nbo;
    end
    check_regions(tag);
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_valid = 1'b1; seed = s;
    @(posedge clk); #1;
    seed_valid = 1'b0;
  endtask

  // l_acc is the LFSR value presented at the acceptance edge
  task automatic do_shuffle(input string tag, input logic [15:0] l_acc);
    logic [15:0] l;
    logic [N-1:0] v;
    logic [N-1:0] rmask;
    logic tmp, got, busy_drop;
    int sz, i, j, ncyc, waited;
    sz = m_s + m_d;
    v = m_cards;
    l = lfsr_step(l_acc);
    i = sz - 1;
    ncyc = 0;
    while (i > 0) begin
      j = int'(l & 16'(fy_mask(i)));
      if (j <= i) begin
        tmp = v[i]; v[i] = v[j]; v[j] = tmp;
        i--;
      end
      ncyc++;
      l = lfsr_step(l);
    end
    rmask = 17'((18'd1 << sz) - 18'd1);
    cmd_valid = 1'b1; cmd_op = OP_SHUFFLE; cmd_idx = 3'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk({tag, "_busy_on"},  32'(busy),      32'd1);
    chk({tag, "_ready_lo"}, 32'(cmd_ready), 32'd0);
    got = 1'b0; busy_drop = 1'b0; waited = 0;
    while (!got && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
      if (rsp_valid) got = 1'b1;
      else if (!busy) busy_drop = 1'b1;
    end
    chk({tag, "_rsp"},      32'(got),       32'd1);
    chk({tag, "_busy_hi"},  32'(busy_drop), 32'd0);
    chk({tag, "_latency"},  32'(waited),    32'(ncyc + 1));
    chk({tag, "_err"},      32'(rsp_err),   32'd0);
    chk({tag, "_busy_off"}, 32'(busy),      32'd0);
    chk({tag, "_popcount"}, 32'($countones(dut.cards & rmask)),
                            32'($countones(m_cards & rmask)));
    m_cards = v; m_s = sz; m_d = 0;
    check_regions(tag);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_idx = 3'd0;
    seed_valid = 1'b0; seed = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready",     32'(cmd_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_lfsr",      32'(dut.lfsr_q), 32'h0000ACE1);
    check_regions("rst");

    do_cmd("status0", OP_STATUS, 0);
    do_cmd("nop",     OP_NOP,    0);
    do_cmd("draw1",   OP_DRAW,   0);
    do_cmd("peek0",   OP_PEEK,   0);
    do_cmd("peek1",   OP_PEEK,   1);
    do_cmd("peek2",   OP_PEEK,   2);
    do_cmd("draw_err",  OP_DRAW,    0);
    do_cmd("peek5_err", OP_PEEK,    5);
    do_cmd("shuf_err",  OP_SHUFFLE, 0);

    do_cmd("rdeck",   OP_RESET_DECK, 0);
    do_cmd("draw2",   OP_DRAW,    0);
    do_cmd("disc_a",  OP_DISCARD, 0);
    do_cmd("disc_b",  OP_DISCARD, 0);
    do_cmd("enact1",  OP_ENACT,   0);
    do_cmd("status1", OP_STATUS,  0);
    chk("status1_const", 32'(rsp_data), 32'h01);
    do_cmd("enact_err", OP_ENACT, 0);

    load_seed(16'h1234);
    do_shuffle("shuf1", 16'h1234);

    do_cmd("draw3",   OP_DRAW,    0);
    do_cmd("peek3_0", OP_PEEK,    0);
    do_cmd("peek3_1", OP_PEEK,    1);
    do_cmd("peek3_2", OP_PEEK,    2);
    do_cmd("disc_c",  OP_DISCARD, 1);
    do_cmd("peek4_0", OP_PEEK,    0);
    do_cmd("peek4_1", OP_PEEK,    1);
    do_cmd("disc_d",  OP_DISCARD, 0);
    do_cmd("disc_err", OP_DISCARD, 0);
    do_cmd("enact2",  OP_ENACT,   0);
    do_cmd("status2", OP_STATUS,  0);

    load_seed(16'h0000);
    chk("seed_zero", 32'(dut.lfsr_q), 32'h0000ACE1);

    cmd_valid = 1'b1; cmd_op = OP_SHUFFLE; cmd_idx = 3'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_busy_on", 32'(busy), 32'd1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("abort_busy",      32'(busy),       32'd0);
    chk("abort_ready",     32'(cmd_ready),  32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid),  32'd0);
    chk("abort_lfsr",      32'(dut.lfsr_q), 32'h0000ACE1);
    check_regions("abort");
    @(posedge clk); #1;
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
